key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Key-event controller that sits downstream of the key debounce/edge filter. It consumes the filter's one-cycle press and release flags and classifies each gesture as single click, double click or long press. It emits one registered event pulse per gesture and drives the two board LEDs from those events. It sequences how the filtered key is used, so later blocks see clean semantic events instead of raw edges.

## Interface
- LONG_CYC, 25_000_000: hold time in clk cycles (500 ms at 50 MHz) that makes a press "long"; must be ≥ 2
- DBL_GAP_CYC, 12_500_000: maximum release-to-second-press gap in cycles (250 ms) for a double click; must be ≥ 2
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- key_press  input  1  one-cycle pulse from the filter, key became pressed
- key_release  input  1  one-cycle pulse from the filter, key became released
- single_evt  output  1  one-cycle pulse, single click recognised
- double_evt  output  1  one-cycle pulse, double click recognised
- long_evt  output  1  one-cycle pulse, long press recognised
- busy  output  1  high while a gesture is in progress (state ≠ IDLE)
- led  output  2  led[0] toggles on single, led[1] toggles on double, both cleared on long; 1 = lit

## Operation
- Counter cnt has width $clog2(max(LONG_CYC, DBL_GAP_CYC)). It is cleared on every state entry and increments by 1 each cycle otherwise. It never wraps, because every state exits before the limit.
- Inputs are qualified first: if key_press and key_release are high in the same cycle, both are ignored and the cycle counts as quiet in every state.
- IDLE: key_press goes to PRESS1. key_release alone is ignored.
- PRESS1:
  - key_release goes to WAIT2. Release has priority over timeout on the same edge.
  - Otherwise, when cnt == LONG_CYC-1, long_evt fires, led becomes 2'b00, and the state goes to LONG_HOLD.
- LONG_HOLD: key_release goes to IDLE. No further events until IDLE is re-entered. A stray key_press is ignored.
- WAIT2:
  - key_press goes to PRESS2. Press has priority over timeout on the same edge.
  - Otherwise, when cnt == DBL_GAP_CYC-1, single_evt fires, led[0] toggles, and the state goes to IDLE.
- PRESS2: key_release fires double_evt, toggles led[1], and goes to IDLE. There is no long detection on the second press. It waits indefinitely.
- Exactly one event per gesture. At most one event output is high in any cycle.
- Reset mid-gesture (rst_n low in any state) aborts silently: no event, state IDLE, cnt 0.

## Timing
- Reset values: single_evt=0, double_evt=0, long_evt=0, busy=0, led=2'b00, state IDLE, cnt=0.
- All outputs are registered.
- Event pulses and the led update change on the same clk edge as the state transition that generates them. Each pulse is high for exactly one cycle.
- Let E0 be the edge that samples key_press in IDLE. Holding gives long_evt high after edge E0+LONG_CYC.
- A release sampled at edge Er enters WAIT2. single_evt is high after edge Er+DBL_GAP_CYC if no press arrives first.
- A press sampled at any edge up to and including Er+DBL_GAP_CYC converts the gesture to a double. double_evt is high after the edge that samples the second release.
- busy rises after E0 and falls after the edge that returns to IDLE.

## Test plan
Test parameters: LONG_CYC=10, DBL_GAP_CYC=6. Edges are numbered from the press edge = 0.
- Reset: hold rst_n=0 with random key pulses -> all outputs 0, led=00. Release reset, then send no key activity -> outputs stay 0.
- Single click: press@0, release@4 -> single_evt one cycle after edge 10, led=01, busy falls after edge 10, no other event.
- Double click: press@0, release@3, press@5, release@8 -> double_evt after edge 8, led[1] toggles, single_evt never asserts. Repeat -> led[1] toggles back.
- Long press: led=11 preloaded via a single then a double. Press@0, hold to release@20 -> long_evt after edge 10 only, led=00, busy falls after edge 20.
- Boundaries:
  - Release@10 -> no long_evt, single_evt after edge 16.
  - Release@4 then press@10 -> double path, no single_evt.
  - Press and release in the same cycle in IDLE -> nothing happens.
- Reset mid-operation: press@0, release@3, rst_n=0 at edge 5 for 2 cycles -> no single_evt, led=00, busy=0. A following clean single click still works.

Source files
------------

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - key gesture classifier: single click, double click, long press
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_press    one-cycle pulse, filtered key became pressed
//   key_release  one-cycle pulse, filtered key became released
//   single_evt   one-cycle pulse, single click recognised
//   double_evt   one-cycle pulse, double click recognised
//   long_evt     one-cycle pulse, long press recognised
//   busy         high while a gesture is in progress
//   led[1:0]     led[0] toggles on single, led[1] toggles on double, both cleared on long
module key_event_ctrl #(
    parameter int LONG_CYC    = 25_000_000,
    parameter int DBL_GAP_CYC = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_press,
    input  logic       key_release,
    output logic       single_evt,
    output logic       double_evt,
    output logic       long_evt,
    output logic       busy,
    output logic [1:0] led
);

    localparam int MAX_CYC = (LONG_CYC > DBL_GAP_CYC) ? LONG_CYC : DBL_GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HOLD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          single_q, single_d;
    logic          double_q, double_d;
    logic          long_q, long_d;
    logic          busy_q, busy_d;
    logic [1:0]    led_q, led_d;

    // A simultaneous press and release is contradictory; treat it as a quiet cycle.
    logic press_ok;
    logic release_ok;
    assign press_ok   = key_press & ~key_release;
    assign release_ok = key_release & ~key_press;

    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        led_d    = led_q;

        case (state_q)
            IDLE: begin
                if (press_ok) state_d = PRESS1;
            end
            PRESS1: begin
                // Release wins over the long timeout on the same edge.
                if (release_ok) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    led_d   = 2'b00;
                    state_d = LONG_HOLD;
                end
            end
            LONG_HOLD: begin
                if (release_ok) state_d = IDLE;
            end
            WAIT2: begin
                // A second press wins over the gap timeout on the same edge.
                if (press_ok) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    single_d  = 1'b1;
                    led_d[0]  = ~led_q[0];
                    state_d   = IDLE;
                end
            end
            PRESS2: begin
                if (release_ok) begin
                    double_d = 1'b1;
                    led_d[1] = ~led_q[1];
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only the two timed states need the counter; elsewhere it rests at zero
        // so it can never wrap while waiting indefinitely.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == PRESS1 || state_q == WAIT2) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
            led_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign single_evt = single_q;
    assign double_evt = double_q;
    assign long_evt   = long_q;
    assign busy       = busy_q;
    assign led        = led_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - self-checking bench for key_event_ctrl
module tb_key_event_ctrl;

    localparam int LONG_CYC    = 10;
    localparam int DBL_GAP_CYC = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_press = 1'b0;
    logic       key_release = 1'b0;
    logic       single_evt;
    logic       double_evt;
    logic       long_evt;
    logic       busy;
    logic [1:0] led;

    key_event_ctrl #(
        .LONG_CYC    (LONG_CYC),
        .DBL_GAP_CYC (DBL_GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_press   (key_press),
        .key_release (key_release),
        .single_evt  (single_evt),
        .double_evt  (double_evt),
        .long_evt    (long_evt),
        .busy        (busy),
        .led         (led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a gesture is described by how many presses it has seen,
    // whether the key is held, whether it already produced a long event, and an
    // absolute deadline (edge number) for the pending timeout.
    int       t_edge;
    int       m_presses;
    bit       m_held;
    bit       m_long_done;
    int       m_deadline;
    bit [1:0] m_led;
    bit       e_single, e_double, e_long;

    int cnt_single, cnt_double, cnt_long;

    task automatic model_reset();
        m_presses   = 0;
        m_held      = 0;
        m_long_done = 0;
        m_deadline  = 0;
        m_led       = 2'b00;
        e_single    = 0;
        e_double    = 0;
        e_long      = 0;
    endtask

    task automatic model_edge(input bit p_in, input bit r_in);
        bit p, r;
        p = p_in && !r_in;
        r = r_in && !p_in;
        e_single = 0;
        e_double = 0;
        e_long   = 0;
        if (m_presses == 0) begin
            if (p) begin
                m_presses   = 1;
                m_held      = 1;
                m_long_done = 0;
                m_deadline  = t_edge + LONG_CYC;
            end
        end else if (m_long_done) begin
            if (r) m_presses = 0;
        end else if (m_presses == 1 && m_held) begin
            if (r) begin
                m_held     = 0;
                m_deadline = t_edge + DBL_GAP_CYC;
            end else if (t_edge == m_deadline) begin
                e_long      = 1;
                m_led       = 2'b00;
                m_long_done = 1;
            end
        end else if (m_presses == 1) begin
            if (p) begin
                m_presses = 2;
                m_held    = 1;
            end else if (t_edge == m_deadline) begin
                e_single  = 1;
                m_led[0]  = ~m_led[0];
                m_presses = 0;
            end
        end else begin
            if (r) begin
                e_double  = 1;
                m_led[1]  = ~m_led[1];
                m_presses = 0;
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".single"}, 32'(single_evt), 32'(e_single));
        chk({ctx, ".double"}, 32'(double_evt), 32'(e_double));
        chk({ctx, ".long"},   32'(long_evt),   32'(e_long));
        chk({ctx, ".busy"},   32'(busy),       32'(m_presses != 0));
        chk({ctx, ".led"},    32'(led),        32'(m_led));
        chk({ctx, ".onehot"}, 32'(32'(single_evt) + 32'(double_evt) + 32'(long_evt) <= 1), 32'd1);
    endtask

    // One clock: drive inputs away from the edge, advance model, check #1 after the edge.
    task automatic cyc(input bit p, input bit r, input string ctx);
        key_press   = p;
        key_release = r;
        @(posedge clk);
        #1;
        t_edge++;
        model_edge(p, r);
        if (single_evt) cnt_single++;
        if (double_evt) cnt_double++;
        if (long_evt)   cnt_long++;
        check_outputs(ctx);
    endtask

    task automatic reset_cycles(input int n, input bit random_keys);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            key_press   = random_keys ? 1'($urandom) : 1'b0;
            key_release = random_keys ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            t_edge++;
            model_reset();
            check_outputs("reset");
        end
        key_press   = 1'b0;
        key_release = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic clear_counts();
        cnt_single = 0;
        cnt_double = 0;
        cnt_long   = 0;
    endtask

    // Edge 0 is the first press; -1 disables an edge.
    task automatic seq(input int rel1, input int pr2, input int rel2, input int last, input string ctx);
        for (int t = 0; t <= last; t++) begin
            cyc(t == 0 || t == pr2, t == rel1 || t == rel2, ctx);
        end
    endtask

    initial begin
        t_edge = 0;
        model_reset();
        clear_counts();

        reset_cycles(5, 1'b1);
        for (int i = 0; i < 5; i++) cyc(0, 0, "quiet");

        // Single click
        clear_counts();
        seq(4, -1, -1, 12, "single");
        chk("single.count", 32'(cnt_single), 32'd1);
        chk("single.others", 32'(cnt_double + cnt_long), 32'd0);
        chk("single.led", 32'(led), 32'h1);

        // Double click twice
        clear_counts();
        seq(3, 5, 8, 10, "double1");
        chk("double1.led", 32'(led), 32'h3);
        seq(3, 5, 8, 10, "double2");
        chk("double2.led", 32'(led), 32'h1);
        chk("double.count", 32'(cnt_double), 32'd2);
        chk("double.nosingle", 32'(cnt_single), 32'd0);

        // Preload led=11, then long press released at edge 20
        seq(3, 5, 8, 10, "preload");
        chk("preload.led", 32'(led), 32'h3);
        clear_counts();
        seq(20, -1, -1, 22, "long");
        chk("long.count", 32'(cnt_long), 32'd1);
        chk("long.others", 32'(cnt_single + cnt_double), 32'd0);
        chk("long.led", 32'(led), 32'h0);

        // Release exactly at the long boundary
        clear_counts();
        seq(10, -1, -1, 18, "rel_at_10");
        chk("rel_at_10.long", 32'(cnt_long), 32'd0);
        chk("rel_at_10.single", 32'(cnt_single), 32'd1);

        // Second press exactly at the gap boundary
        clear_counts();
        seq(4, 10, 12, 14, "press_at_gap");
        chk("press_at_gap.single", 32'(cnt_single), 32'd0);
        chk("press_at_gap.double", 32'(cnt_double), 32'd1);

        // Simultaneous press and release in idle
        clear_counts();
        cyc(1, 1, "both");
        for (int i = 0; i < 12; i++) cyc(0, 0, "both_tail");
        chk("both.busy", 32'(busy), 32'd0);
        chk("both.events", 32'(cnt_single + cnt_double + cnt_long), 32'd0);

        // Reset in the middle of a gesture
        clear_counts();
        seq(3, -1, -1, 4, "midrst");
        reset_cycles(2, 1'b0);
        for (int i = 0; i < 10; i++) cyc(0, 0, "midrst_tail");
        chk("midrst.single", 32'(cnt_single), 32'd0);
        chk("midrst.led", 32'(led), 32'h0);
        chk("midrst.busy", 32'(busy), 32'd0);
        clear_counts();
        seq(4, -1, -1, 12, "after_rst");
        chk("after_rst.single", 32'(cnt_single), 32'd1);

        // Random pulse traffic, including overlapping pulses and long quiet spells
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = int'($urandom_range(0, 99));
            if (mode < 10)      cyc(1, 0, "rand");
            else if (mode < 20) cyc(0, 1, "rand");
            else if (mode < 22) cyc(1, 1, "rand");
            else                cyc(0, 0, "rand");
            if (i % 700 == 699) reset_cycles(int'($urandom_range(1, 3)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
